// File: rtl/capture_readout_if.sv
// Readout handshake bundle: BRAM read port, sample stream and status.
// master = readout block, slave = BRAM/consumer side.
interface capture_readout_if #(
    parameter int NB_ADDR   = 11,
    parameter int NB_DATA   = 32,
    parameter int NB_SAMPLE = 13
);
    logic                 i_start;
    logic [NB_ADDR-1:0]   o_read_addr;
    logic                 o_read_enable;
    logic [NB_DATA-1:0]   i_bram_data;
    logic [NB_SAMPLE-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        input  i_start, i_bram_data, i_ready,
        output o_read_addr, o_read_enable, o_data,
        output o_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_bram_data, i_ready,
        input  o_read_addr, o_read_enable, o_data,
        input  o_valid, o_busy, o_done
    );
endinterface

// File: rtl/capture_readout.sv
// Streams the captured sample buffer out of BRAM over valid/ready.
// Optional READOUT_CHECKSUM_EN appends a mod-2**NB_SAMPLE sum word.
module capture_readout #(
    parameter int NB_ADDR   = 11,
    parameter int NB_DATA   = 32,
    parameter int NB_SAMPLE = 13,
    parameter int N_SAMPLES = 2047
) (
    input  logic clock,
    input  logic i_reset,
    capture_readout_if.master bus
);
`ifdef READOUT_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, PRESENT, CSUM, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, PRESENT, DONE
    } state_t;
`endif

    localparam logic [NB_ADDR-1:0] LAST = NB_ADDR'(N_SAMPLES - 1);

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   cnt_q, cnt_d;
    logic [NB_SAMPLE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 accept;
`ifdef READOUT_CHECKSUM_EN
    logic [NB_SAMPLE-1:0] sum_q, sum_d;
`endif

    assign accept = valid_q & bus.i_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef READOUT_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
`ifdef READOUT_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                data_d  = bus.i_bram_data[NB_SAMPLE-1:0];
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    valid_d = 1'b0;
`ifdef READOUT_CHECKSUM_EN
                    sum_d   = sum_q + data_q;
`endif
                    if (cnt_q == LAST) begin
`ifdef READOUT_CHECKSUM_EN
                        // Checksum word goes out with the same handshake
                        data_d  = sum_q + data_q;
                        valid_d = 1'b1;
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
`ifdef READOUT_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef READOUT_CHECKSUM_EN
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) sum_q <= '0;
        else          sum_q <= sum_d;
    end
`endif

    assign bus.o_read_addr   = cnt_q;
    assign bus.o_read_enable = (state_q == ISSUE);
    assign bus.o_data        = data_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_done        = (state_q == DONE);
endmodule

// File: tb/tb_capture_readout.sv
// Scoreboard bench for capture_readout with N_SAMPLES=4.
// Expected words/addresses are queued by stimulus, popped by a monitor.
module tb_capture_readout;
    localparam int NA = 11;
    localparam int ND = 32;
    localparam int NS = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    capture_readout_if #(.NB_ADDR(NA), .NB_DATA(ND), .NB_SAMPLE(NS)) bus();

    capture_readout #(
        .NB_ADDR(NA), .NB_DATA(ND), .NB_SAMPLE(NS), .N_SAMPLES(4)
    ) dut (
        .clock(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    logic [31:0] mem [0:3];
    always @(posedge clk)
        if (bus.o_read_enable) bus.i_bram_data <= mem[bus.o_read_addr[1:0]];

    logic [NS-1:0] exp_q[$];
    logic [NA-1:0] addr_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int re_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_valid && bus.i_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) check("unexpected_word", 32'(bus.o_data), 32'hFFFF_FFFF);
                else check("word", 32'(bus.o_data), 32'(exp_q.pop_front()));
            end
            if (bus.o_read_enable) begin
                re_cnt++;
                if (addr_q.size() == 0) check("extra_read", 32'(bus.o_read_addr), 32'hFFFF_FFFF);
                else check("read_addr", 32'(bus.o_read_addr), 32'(addr_q.pop_front()));
            end
            if (bus.o_done) done_cnt++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(bus.o_read_addr), 0);
        check({tag, "_ren"},   32'(bus.o_read_enable), 0);
        check({tag, "_data"},  32'(bus.o_data), 0);
        check({tag, "_valid"}, 32'(bus.o_valid), 0);
        check({tag, "_busy"},  32'(bus.o_busy), 0);
        check({tag, "_done"},  32'(bus.o_done), 0);
    endtask

    task automatic expect_run(input logic [NS-1:0] w0, input logic [NS-1:0] w1,
                              input logic [NS-1:0] w2, input logic [NS-1:0] w3,
                              input logic [NS-1:0] csum);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        exp_q.push_back(w3);
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(csum);
`else
        if (csum == 0) begin end
`endif
        for (int i = 0; i < 4; i++) addr_q.push_back(NA'(i));
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #2;
            if (acc_cnt >= n) ok = 1;
        end
        if (!ok) check("wait_acc_timeout", 0, 1);
    endtask

    task automatic wait_done(input string tag);
        int base = done_cnt;
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #2;
            if (done_cnt > base) ok = 1;
        end
        if (!ok) check({tag, "_done_timeout"}, 0, 1);
        else begin
            check({tag, "_busy_after_done"}, 32'(bus.o_busy), 0);
            repeat (5) @(posedge clk);
            #1;
            check({tag, "_done_pulses"}, 32'(done_cnt - base), 1);
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 5);

        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic run with latency check
        expect_run(5, 6, 7, 8, 13'd26);
        pulse_start();
        check("lat_busy", 32'(bus.o_busy), 1);
        check("lat_ren", 32'(bus.o_read_enable), 1);
        check("lat_valid0", 32'(bus.o_valid), 0);
        @(posedge clk); #1;
        check("lat_valid1", 32'(bus.o_valid), 0);
        @(posedge clk); #1;
        check("lat_valid2", 32'(bus.o_valid), 1);
        check("lat_data", 32'(bus.o_data), 5);
        wait_done("basic");

        // backpressure on first word
        bus.i_ready = 1'b0;
        expect_run(5, 6, 7, 8, 13'd26);
        pulse_start();
        begin
            bit seen = 0;
            int re0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk); #2;
                if (bus.o_valid) seen = 1;
            end
            if (!seen) check("bp_valid_timeout", 0, 1);
            re0 = re_cnt;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #2;
                check("bp_valid", 32'(bus.o_valid), 1);
                check("bp_data", 32'(bus.o_data), 5);
            end
            check("bp_no_reads", 32'(re_cnt - re0), 0);
        end
        bus.i_ready = 1'b1;
        wait_done("bp");

        // start pulse mid-readout is ignored
        acc_cnt = 0;
        expect_run(5, 6, 7, 8, 13'd26);
        pulse_start();
        wait_acc(2);
        pulse_start();
        wait_done("restart_ignored");

        // async reset mid-readout, then restart from address 0
        acc_cnt = 0;
        expect_run(5, 6, 7, 8, 13'd26);
        pulse_start();
        wait_acc(2);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_run(5, 6, 7, 8, 13'd26);
        pulse_start();
        wait_done("after_rst");

        // upper bits discarded; checksum wraps mod 2**13
        mem[0] = 32'hDEAD_FFFF;
        mem[1] = 32'h0000_0002;
        mem[2] = 32'h0000_0003;
        mem[3] = 32'hFFFF_E000;
        acc_cnt = 0;
        expect_run(13'h1FFF, 13'h0002, 13'h0003, 13'h0000, 13'h0004);
        pulse_start();
        wait_done("csum");
`ifdef READOUT_CHECKSUM_EN
        check("csum_word_count", 32'(acc_cnt), 5);
`else
        check("csum_word_count", 32'(acc_cnt), 4);
`endif

        check("exp_q_empty", 32'(exp_q.size()), 0);
        check("addr_q_empty", 32'(addr_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
